mem_access_unit: RTL and testbench

- Multicycle load/store sequencer between the CPU datapath and data_memory. It sits directly upstream and drives the data memory's enables, address and write data.
- Decodes the 14-bit word address: addr[13]=0 goes to data_memory (0x0000-0x1FFF); addr[13]=1 goes to a small internal memory-mapped I/O bank (0x2000-0x3FFF).
- Gives the CPU a req/ready handshake, so the CPU controller never tracks synchronous-RAM read latency itself.

---
 rtl/mem_access_pkg.sv | 21 ++
 rtl/mem_io_regs.sv | 93 +++++++++
 rtl/mem_access_unit.sv | 139 +++++++++++++
 tb/tb_mem_access_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the load/store sequencer and its I/O register bank.
package mem_access_pkg;

    localparam int DATA_W_DEF = 24;
    localparam int ADDR_W_DEF = 14;
    localparam int OFFSET_W   = ADDR_W_DEF - 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DMEM  = 3'd1,
        DWAIT = 3'd2,
        IO    = 3'd3,
        RESP  = 3'd4
    } state_e;

    localparam logic [OFFSET_W-1:0] IO_OUT     = 13'h0000;
    localparam logic [OFFSET_W-1:0] IO_IN      = 13'h0001;
    localparam logic [OFFSET_W-1:0] IO_SCRATCH = 13'h0002;
    localparam logic [OFFSET_W-1:0] IO_CYCLE   = 13'h0003;

endpackage

// File: rtl/mem_io_regs.sv
// Memory-mapped I/O bank: io_out, synchronized io_in, scratch and, when
// MEM_ACCESS_CYCLE_CNT_EN is defined, a free-running cycle counter.
module mem_io_regs
    import mem_access_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sel_i,
    input  logic              we_i,
    input  logic [ADDR_W-2:0] offset_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] io_in_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic [DATA_W-1:0] io_out_o
);

    logic [DATA_W-1:0] io_out_q;
    logic [DATA_W-1:0] scratch_q;
    logic [DATA_W-1:0] sync_q [SYNC_STAGES];
    logic              wr_out_s;
    logic              wr_scr_s;
`ifdef MEM_ACCESS_CYCLE_CNT_EN
    logic [DATA_W-1:0] cnt_q;
    logic              wr_cnt_s;
`endif

    // Read decode and unmapped-offset detection; unmapped loads return zero.
    always_comb begin
        rdata_o = '0;
        err_o   = 1'b0;
        case (offset_i)
            IO_OUT:     rdata_o = io_out_q;
            IO_IN:      rdata_o = sync_q[SYNC_STAGES-1];
            IO_SCRATCH: rdata_o = scratch_q;
`ifdef MEM_ACCESS_CYCLE_CNT_EN
            IO_CYCLE:   rdata_o = cnt_q;
`endif
            default:    err_o   = 1'b1;
        endcase
    end

    // Write strobes, qualified by an active I/O store.
    always_comb begin
        wr_out_s = sel_i && we_i && (offset_i == IO_OUT);
        wr_scr_s = sel_i && we_i && (offset_i == IO_SCRATCH);
`ifdef MEM_ACCESS_CYCLE_CNT_EN
        wr_cnt_s = sel_i && we_i && (offset_i == IO_CYCLE);
`endif
    end

    // Writable registers and the io_in synchronizer chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            io_out_q  <= '0;
            scratch_q <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            if (wr_out_s) begin
                io_out_q <= wdata_i;
            end
            if (wr_scr_s) begin
                scratch_q <= wdata_i;
            end
            sync_q[0] <= io_in_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

`ifdef MEM_ACCESS_CYCLE_CNT_EN
    // Free-running counter; a store to its offset restarts it from zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (wr_cnt_s) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DATA_W'(1);
        end
    end
`endif

    assign io_out_o = io_out_q;

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle load/store sequencer: CPU req/ready handshake, data_memory strobes
// and I/O bank dispatch. Cycle counter at 0x2003 enabled by MEM_ACCESS_CYCLE_CNT_EN.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic              dmem_we,
    output logic              dmem_re,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic [DATA_W-1:0] io_in,
    output logic [DATA_W-1:0] io_out
);

    state_e            state_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ready_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic              dmem_we_q;
    logic              dmem_re_q;
    logic [DATA_W-1:0] io_rdata_s;
    logic              io_err_s;
    logic              io_sel_s;

    assign io_sel_s = (state_q == IO);

    mem_io_regs #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_io_regs (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .sel_i    (io_sel_s),
        .we_i     (we_q),
        .offset_i (addr_q[ADDR_W-2:0]),
        .wdata_i  (wdata_q),
        .io_in_i  (io_in),
        .rdata_o  (io_rdata_s),
        .err_o    (io_err_s),
        .io_out_o (io_out)
    );

    // Sequencer FSM; strobes and handshake outputs are set one state early so they are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            dmem_we_q <= 1'b0;
            dmem_re_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    if (cpu_req) begin
                        we_q    <= cpu_we;
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                        if (!cpu_addr[ADDR_W-1]) begin
                            state_q   <= DMEM;
                            dmem_we_q <= cpu_we;
                            dmem_re_q <= ~cpu_we;
                        end else begin
                            state_q <= IO;
                        end
                    end
                end
                DMEM: begin
                    dmem_we_q <= 1'b0;
                    dmem_re_q <= 1'b0;
                    if (we_q) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                        err_q   <= 1'b0;
                    end else begin
                        state_q <= DWAIT;
                    end
                end
                DWAIT: begin
                    rdata_q <= dmem_rdata;
                    ready_q <= 1'b1;
                    err_q   <= 1'b0;
                    state_q <= RESP;
                end
                IO: begin
                    if (!we_q) begin
                        rdata_q <= io_rdata_s;
                    end
                    ready_q <= 1'b1;
                    err_q   <= io_err_s;
                    state_q <= RESP;
                end
                RESP: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q   <= 1'b0;
                    err_q     <= 1'b0;
                    dmem_we_q <= 1'b0;
                    dmem_re_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign cpu_ready  = ready_q;
    assign cpu_err    = err_q;
    assign cpu_rdata  = rdata_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_re    = dmem_re_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural synchronous data_memory attached.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    typedef struct {
        logic        we;
        logic [13:0] addr;
        logic [23:0] wdata;
        logic [23:0] rdata;
        logic        err;
        int          lat;
        int          nwe;
        int          nre;
    } vec_t;

    typedef struct {
        logic [23:0] rdata;
        logic        err;
        int          lat;
        int          nwe;
        int          nre;
        logic        chk_rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [13:0] cpu_addr;
    logic [23:0] cpu_wdata;
    logic        cpu_ready, cpu_err;
    logic [23:0] cpu_rdata;
    logic        dmem_we, dmem_re;
    logic [13:0] dmem_addr;
    logic [23:0] dmem_wdata, dmem_rdata, io_in, io_out;

    logic [23:0] mem [0:8191];
    int          pcnt = 0;
    int          drive_cyc;
    int          checks = 0;
    int          errors = 0;
    int          both_cnt = 0;
    exp_t        sb[$];
    vec_t        vecs[$];
    logic [23:0] m_io_out;
    int          exp_cyc[4] = '{3, 6, 10, 13};

    mem_access_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .cpu_err    (cpu_err),
        .dmem_we    (dmem_we),
        .dmem_re    (dmem_re),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .io_in      (io_in),
        .io_out     (io_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pcnt <= pcnt + 1;
        if (dmem_we) mem[dmem_addr[12:0]] <= dmem_wdata;
        if (dmem_re) dmem_rdata <= mem[dmem_addr[12:0]];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic access(input logic we, input logic [13:0] addr, input logic [23:0] wdata, input exp_t e);
        int   nwe = 0;
        int   nre = 0;
        bit   done = 1'b0;
        exp_t x;
        sb.push_back(e);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        drive_cyc = pcnt;
        for (int i = 1; i <= 8 && !done; i++) begin
            @(negedge clk);
            if (i == 1) cpu_req = 1'b0;
            if (dmem_we && dmem_re) both_cnt++;
            if (dmem_we) begin
                nwe++;
                chk("dmem_addr_wr", 32'(dmem_addr), 32'(addr));
                chk("dmem_wdata", 32'(dmem_wdata), 32'(wdata));
            end
            if (dmem_re) begin
                nre++;
                chk("dmem_addr_rd", 32'(dmem_addr), 32'(addr));
            end
            if (cpu_ready) begin
                done = 1'b1;
                x = sb.pop_front();
                chk("latency", 32'(i), 32'(x.lat));
                chk("cpu_err", 32'(cpu_err), 32'(x.err));
                if (x.chk_rdata) chk("cpu_rdata", 32'(cpu_rdata), 32'(x.rdata));
                chk("dmem_we_pulses", 32'(nwe), 32'(x.nwe));
                chk("dmem_re_pulses", 32'(nre), 32'(x.nre));
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL ready_timeout: addr %0h got no ready, required ready within 8 cycles", addr);
            void'(sb.pop_front());
        end
        @(negedge clk);
        chk("ready_one_cycle", 32'(cpu_ready), 32'd0);
    endtask

    function automatic vec_t mk(logic we, logic [13:0] a, logic [23:0] wd, logic [23:0] rd,
                                logic err, int lat, int nwe, int nre);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = wd; v.rdata = rd;
        v.err = err; v.lat = lat; v.nwe = nwe; v.nre = nre;
        return v;
    endfunction

    initial begin
        exp_t e;
        int   nready, nre, bad;
        vecs.push_back(mk(1'b1, 14'h0010, 24'h00ABCD, 24'h0,      1'b0, 2, 1, 0));
        vecs.push_back(mk(1'b0, 14'h0010, 24'h0,      24'h00ABCD, 1'b0, 3, 0, 1));
        vecs.push_back(mk(1'b1, 14'h0001, 24'h000111, 24'h0,      1'b0, 2, 1, 0));
        vecs.push_back(mk(1'b1, 14'h1FFF, 24'h5A5A5A, 24'h0,      1'b0, 2, 1, 0));
        vecs.push_back(mk(1'b0, 14'h1FFF, 24'h0,      24'h5A5A5A, 1'b0, 3, 0, 1));
        vecs.push_back(mk(1'b1, 14'h2000, 24'h123456, 24'h0,      1'b0, 2, 0, 0));
        vecs.push_back(mk(1'b0, 14'h2000, 24'h0,      24'h123456, 1'b0, 2, 0, 0));
        vecs.push_back(mk(1'b1, 14'h2002, 24'hA5A5A5, 24'h0,      1'b0, 2, 0, 0));
        vecs.push_back(mk(1'b0, 14'h2002, 24'h0,      24'hA5A5A5, 1'b0, 2, 0, 0));
        vecs.push_back(mk(1'b0, 14'h2001, 24'h0,      24'h00FF00, 1'b0, 2, 0, 0));
        vecs.push_back(mk(1'b1, 14'h2001, 24'h000007, 24'h0,      1'b0, 2, 0, 0));
        vecs.push_back(mk(1'b0, 14'h2001, 24'h0,      24'h00FF00, 1'b0, 2, 0, 0));
        vecs.push_back(mk(1'b0, 14'h2100, 24'h0,      24'h000000, 1'b1, 2, 0, 0));
        vecs.push_back(mk(1'b1, 14'h3FFF, 24'h777777, 24'h0,      1'b1, 2, 0, 0));
        vecs.push_back(mk(1'b0, 14'h2000, 24'h0,      24'h123456, 1'b0, 2, 0, 0));
        vecs.push_back(mk(1'b0, 14'h2002, 24'h0,      24'hA5A5A5, 1'b0, 2, 0, 0));
`ifndef MEM_ACCESS_CYCLE_CNT_EN
        vecs.push_back(mk(1'b0, 14'h2003, 24'h0,      24'h000000, 1'b1, 2, 0, 0));
`endif

        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 14'h0;
        cpu_wdata = 24'h0; io_in = 24'h0; m_io_out = 24'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cpu_ready), 32'd0);
        chk("rst_err", 32'(cpu_err), 32'd0);
        chk("rst_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_strobes", 32'({dmem_we, dmem_re}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_io_out", 32'(io_out), 32'd0);
        io_in = 24'h00FF00;
        repeat (3) @(negedge clk);

        foreach (vecs[k]) begin
            e.rdata = vecs[k].rdata; e.err = vecs[k].err; e.lat = vecs[k].lat;
            e.nwe = vecs[k].nwe; e.nre = vecs[k].nre; e.chk_rdata = ~vecs[k].we;
            access(vecs[k].we, vecs[k].addr, vecs[k].wdata, e);
            if (vecs[k].we && vecs[k].addr == 14'h2000) m_io_out = vecs[k].wdata;
            chk("io_out", 32'(io_out), 32'(m_io_out));
        end

        // Request held high, alternating dmem/IO addresses.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0001;
        nready = 0; nre = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (dmem_re) nre++;
            if (dmem_we && dmem_re) both_cnt++;
            if (cpu_ready) begin
                if (nready < 4) begin
                    chk("held_ready_cycle", 32'(k), 32'(exp_cyc[nready]));
                    chk("held_rdata", 32'(cpu_rdata), (nready % 2 == 0) ? 32'h000111 : 32'hA5A5A5);
                end
                nready++;
                cpu_addr = (cpu_addr == 14'h0001) ? 14'h2002 : 14'h0001;
                if (nready == 4) cpu_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        chk("held_ready_count", 32'(nready), 32'd4);
        chk("held_re_count", 32'(nre), 32'd2);

`ifdef MEM_ACCESS_CYCLE_CNT_EN
        begin
            int a;
            e.rdata = 24'h0; e.err = 1'b0; e.lat = 2; e.nwe = 0; e.nre = 0; e.chk_rdata = 1'b0;
            access(1'b1, 14'h2003, 24'h000055, e);
            a = drive_cyc;
            repeat (3) @(negedge clk);
            e.rdata = 24'(pcnt - a); e.chk_rdata = 1'b1;
            access(1'b0, 14'h2003, 24'h0, e);
        end
`endif

        // Asynchronous reset while a load sits in DWAIT.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0010;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("mid_state_dwait", 32'(dut.state_q), 32'(DWAIT));
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_outputs", 32'({cpu_ready, cpu_err, dmem_we, dmem_re}), 32'd0);
        chk("mid_rst_rdata", 32'(cpu_rdata), 32'd0);
        chk("mid_rst_io_out", 32'(io_out), 32'd0);
        chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
        rst_n = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (dmem_we || dmem_re || cpu_ready) bad++;
        end
        chk("post_rst_quiet", 32'(bad), 32'd0);
        chk("post_rst_io_out", 32'(io_out), 32'd0);
        chk("never_both_strobes", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
